// File: rtl/serializador_pkg.sv
// serializador_pkg
// Shared definitions for the byte-to-bitstream transmitter.
//   ser_state_t : transmitter FSM state encoding (IDLE / SEND / GAP)
//   SER_STATS_W : width of the optional sent-byte counter
package serializador_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } ser_state_t;

  localparam int SER_STATS_W = 16;

endpackage

// File: rtl/serializador.sv
// serializador
// Parallel-to-serial transmitter feeding the deserializer in the 100 kHz
// domain. A byte is taken over a valid/ready handshake and shifted out MSB
// first, one bit per cycle, on data_out/write_out. While status_in is high
// (deserializer full) the shift stalls without losing or repeating bits.
// After each byte, GAP_CYCLES idle cycles are inserted.
//
// Parameters:
//   DATA_WIDTH  bits per byte (>= 2)
//   GAP_CYCLES  idle cycles after each byte (0 allowed)
// Ports:
//   clk_100KHz  in   system clock, rising edge
//   reset       in   asynchronous, active-low
//   byte_in     in   parallel byte to send
//   byte_valid  in   byte_in valid
//   byte_ready  out  transmitter can take a byte this cycle (state IDLE)
//   status_in   in   deserializer status_out, 1 = cannot accept bits
//   data_out    out  serial bit (to deserializer data_in)
//   write_out   out  data_out valid this cycle (to deserializer write_in)
//   busy        out  byte in flight or gap active
//   bytes_sent  out  16-bit wrapping count of completed bytes
//                    (only when SERIALIZADOR_STATS_EN is defined)
//
// Optional feature macro: SERIALIZADOR_STATS_EN
module serializador
  import serializador_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  status_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy
`ifdef SERIALIZADOR_STATS_EN
  ,
  output logic [SER_STATS_W-1:0] bytes_sent
`endif
);

  localparam int BIT_W      = $clog2(DATA_WIDTH + 1);
  localparam int GAP_RAW_W  = $clog2(GAP_CYCLES + 1);
  localparam int GAP_W      = (GAP_RAW_W < 1) ? 1 : GAP_RAW_W;
  // Gap counter is loaded with GAP_CYCLES-1 and leaves GAP when it reads 0,
  // giving exactly GAP_CYCLES cycles in GAP.
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  localparam logic [BIT_W-1:0]      BIT_LOAD   = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0]      BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0]      BIT_ZERO   = {BIT_W{1'b0}};
  localparam logic [GAP_W-1:0]      GAP_LOAD   = GAP_W'(GAP_LOAD_I);
  localparam logic [GAP_W-1:0]      GAP_ONE    = GAP_W'(1);
  localparam logic [GAP_W-1:0]      GAP_ZERO   = {GAP_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] SHIFT_ZERO = {DATA_WIDTH{1'b0}};

  ser_state_t            state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [GAP_W-1:0]      gap_cnt_r;

  logic advance_s;
  logic last_bit_s;

  // Bit advance qualifiers: a bit leaves only in SEND when the sink is not stalling.
  always_comb begin
    advance_s  = 1'b0;
    last_bit_s = 1'b0;
    if (state_r == S_SEND) begin
      advance_s  = ~status_in;
      last_bit_s = ~status_in & (bit_cnt_r == BIT_ONE);
    end else begin
      advance_s  = 1'b0;
      last_bit_s = 1'b0;
    end
  end

  // Output decode: combinational so a stall suppresses write_out in the same cycle.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b1;
    write_out  = 1'b0;
    data_out   = 1'b0;
    case (state_r)
      S_IDLE: begin
        byte_ready = 1'b1;
        busy       = 1'b0;
      end
      S_SEND: begin
        write_out = ~status_in;
        // MSB stays on the line during a stall so the sink sees a stable value.
        data_out  = shift_r[DATA_WIDTH-1];
      end
      S_GAP: begin
        write_out = 1'b0;
      end
      default: begin
        byte_ready = 1'b0;
        busy       = 1'b1;
      end
    endcase
  end

  // Transmitter FSM with shift register, bit counter and gap counter.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      shift_r   <= SHIFT_ZERO;
      bit_cnt_r <= BIT_ZERO;
      gap_cnt_r <= GAP_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (byte_valid) begin
            shift_r   <= byte_in;
            bit_cnt_r <= BIT_LOAD;
            state_r   <= S_SEND;
          end
        end
        S_SEND: begin
          if (advance_s) begin
            shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - BIT_ONE;
            if (last_bit_s) begin
              if (GAP_CYCLES > 0) begin
                gap_cnt_r <= GAP_LOAD;
                state_r   <= S_GAP;
              end else begin
                state_r <= S_IDLE;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_r == GAP_ZERO) begin
            state_r <= S_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle state.
          state_r   <= S_IDLE;
          shift_r   <= SHIFT_ZERO;
          bit_cnt_r <= BIT_ZERO;
          gap_cnt_r <= GAP_ZERO;
        end
      endcase
    end
  end

`ifdef SERIALIZADOR_STATS_EN
  logic [SER_STATS_W-1:0] bytes_sent_r;

  // Completed-byte counter: bumps on the cycle the last bit is written, wraps naturally.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      bytes_sent_r <= {SER_STATS_W{1'b0}};
    end else if (last_bit_s) begin
      bytes_sent_r <= bytes_sent_r + SER_STATS_W'(1);
    end
  end

  assign bytes_sent = bytes_sent_r;
`endif

endmodule

// File: tb/tb_serializador.sv
// tb_serializador
// Directed self-checking bench for serializador (DATA_WIDTH=8, GAP_CYCLES=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 2 time units after the rising edge.
module tb_serializador;
  import serializador_pkg::*;

  logic       clk_100KHz;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       status_in;
  logic       data_out;
  logic       write_out;
  logic       busy;
`ifdef SERIALIZADOR_STATS_EN
  logic [SER_STATS_W-1:0] bytes_sent;
`endif

  int errors = 0;
  int checks = 0;

  serializador #(.DATA_WIDTH(8), .GAP_CYCLES(2)) dut (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .status_in  (status_in),
    .data_out   (data_out),
    .write_out  (write_out),
    .busy       (busy)
`ifdef SERIALIZADOR_STATS_EN
    ,
    .bytes_sent (bytes_sent)
`endif
  );

  initial clk_100KHz = 1'b0;
  always #5 clk_100KHz = ~clk_100KHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100KHz);
    #1;
  endtask

  // Hand one byte over from IDLE and wait (bounded) until the transmitter is idle again.
  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    n = 0;
    #1;
    while (!byte_ready && n < 40) begin
      tick();
      #1;
      n++;
    end
    check("send_byte_done", {31'd0, byte_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] rx;
    int nwr;
    int k;
    int n;
    int gapc;
    logic exp_ready;
    logic exp_write;

    byte_in    = 8'h00;
    byte_valid = 1'b0;
    status_in  = 1'b0;
    reset      = 1'b1;
    #2 reset = 1'b0;
    #1;

    // ---- reset state ----
    check("rst_ready", {31'd0, byte_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_write", {31'd0, write_out},  32'd0);
    check("rst_data",  {31'd0, data_out},   32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    #1;
    check("idle_ready", {31'd0, byte_ready}, 32'd1);
    check("idle_busy",  {31'd0, busy},       32'd0);
    check("idle_write", {31'd0, write_out},  32'd0);

    // ---- 0xA5, no stalls ----
    pat        = 8'hA5;
    byte_in    = pat;
    byte_valid = 1'b1;
    #1;
    check("a5_ready_accept", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    for (int c = 1; c <= 11; c++) begin
      #1;
      if (c <= 8) begin
        check("a5_write", {31'd0, write_out}, 32'd1);
        check("a5_data",  {31'd0, data_out},  {31'd0, pat[8-c]});
        check("a5_ready_low", {31'd0, byte_ready}, 32'd0);
      end else if (c <= 10) begin
        check("a5_gap_write", {31'd0, write_out}, 32'd0);
        check("a5_gap_busy",  {31'd0, busy},      32'd1);
        check("a5_gap_ready", {31'd0, byte_ready}, 32'd0);
      end else begin
        check("a5_ready_back", {31'd0, byte_ready}, 32'd1);
        check("a5_busy_clear", {31'd0, busy},       32'd0);
      end
      tick();
    end

    // ---- 0x3C with stall in SEND cycles 3..5 ----
    byte_in    = 8'h3C;
    byte_valid = 1'b1;
    #1;
    check("3c_ready_accept", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
    rx  = 8'h00;
    nwr = 0;
    k   = 0;
    while (nwr < 8 && k < 30) begin
      k++;
      status_in = (k >= 3 && k <= 5);
      #1;
      if (status_in) begin
        check("3c_stall_write", {31'd0, write_out}, 32'd0);
        check("3c_stall_data",  {31'd0, data_out},  32'd1);
        check("3c_stall_busy",  {31'd0, busy},      32'd1);
      end
      if (write_out) begin
        rx = {rx[6:0], data_out};
        nwr++;
      end
      tick();
    end
    status_in = 1'b0;
    check("3c_bits",    {24'd0, rx}, 32'h3C);
    check("3c_nwrites", nwr,         32'd8);
    check("3c_latency", k,           32'd11);
    n = 0;
    #1;
    while (!byte_ready && n < 10) begin
      tick();
      #1;
      n++;
    end
    check("3c_gap_len", n, 32'd2);

    // ---- back-to-back 0xFF then 0x00, byte_valid held ----
    tick();
    byte_in    = 8'hFF;
    byte_valid = 1'b1;
    gapc       = 0;
    for (int c = 0; c <= 22; c++) begin
      #1;
      exp_ready = (c == 0 || c == 11 || c == 22);
      exp_write = (c >= 1 && c <= 8) || (c >= 12 && c <= 19);
      check("b2b_ready", {31'd0, byte_ready}, {31'd0, exp_ready});
      check("b2b_write", {31'd0, write_out},  {31'd0, exp_write});
      check("b2b_busy",  {31'd0, busy},       {31'd0, ~exp_ready});
      if (exp_write) begin
        check("b2b_data", {31'd0, data_out}, (c <= 8) ? 32'd1 : 32'd0);
      end
      if (c < 11 && busy && !write_out) gapc++;
      if (c == 22) byte_valid = 1'b0;
      tick();
      if (c == 0) byte_in = 8'h00;
    end
    check("b2b_gap_cycles", gapc, 32'd2);

    // ---- reset mid-byte during 0x81 ----
    pat        = 8'h81;
    byte_in    = pat;
    byte_valid = 1'b1;
    #1;
    check("81_ready_accept", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("81a_write", {31'd0, write_out}, 32'd1);
      check("81a_data",  {31'd0, data_out},  {31'd0, pat[8-c]});
      tick();
    end
    reset = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd1);
    check("mid_rst_busy",  {31'd0, busy},       32'd0);
    check("mid_rst_write", {31'd0, write_out},  32'd0);
    check("mid_rst_data",  {31'd0, data_out},   32'd0);
    tick();
    reset = 1'b1;
    tick();
    byte_valid = 1'b1;
    #1;
    check("81b_ready_accept", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      check("81b_write", {31'd0, write_out}, 32'd1);
      check("81b_data",  {31'd0, data_out},  {31'd0, pat[8-c]});
      tick();
    end
    #1;
    check("81b_after_write", {31'd0, write_out}, 32'd0);
    n = 0;
    while (!byte_ready && n < 10) begin
      tick();
      #1;
      n++;
    end
    check("81b_idle", {31'd0, byte_ready}, 32'd1);

`ifdef SERIALIZADOR_STATS_EN
    // ---- statistics counter ----
    check("stats_one", {16'd0, bytes_sent}, 32'd1);
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    check("stats_three", {16'd0, bytes_sent}, 32'd3);
    dut.bytes_sent_r = 16'hFFFF;
    #1;
    check("stats_preload", {16'd0, bytes_sent}, 32'h0000FFFF);
    tick();
    send_byte(8'h33);
    check("stats_wrap", {16'd0, bytes_sent}, 32'd0);
`else
    tick();
    send_byte(8'h5A);
    check("final_busy", {31'd0, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
